// File: rtl/uart_data_sender_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_data_sender_if
//  Description : Signal bundle between uart_data_sender, its control block,
//                its receive buffer (synchronous RAM) and the UART line.
//                master : the sender side (drives buffer reads and txd)
//                slave  : the environment side (control, buffer, line)
//  Signals     : data_send_run    - level run request from the control block
//                rd_en / rd_addr  - buffer read request
//                rd_data          - buffer read data, one clock after request
//                txd              - UART serial output, idle high
//                busy             - run in progress
//                data_send_finish - one-clock pulse after the last stop bit
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_data_sender_if #(
    parameter int ADDR_W = 14
);
    logic              data_send_run;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic              txd;
    logic              busy;
    logic              data_send_finish;

    modport master (
        input  data_send_run,
        input  rd_data,
        output rd_en,
        output rd_addr,
        output txd,
        output busy,
        output data_send_finish
    );

    modport slave (
        output data_send_run,
        output rd_data,
        input  rd_en,
        input  rd_addr,
        input  txd,
        input  busy,
        input  data_send_finish
    );
endinterface
`default_nettype wire

// File: rtl/uart_data_sender.sv
`default_nettype none
// ============================================================================
//  Module      : uart_data_sender
//  Description : On a rising edge of data_send_run (seen in IDLE), reads
//                DATA_COUNT bytes from a synchronous-read buffer and sends
//                each one as an 8N1 UART frame on txd, LSB first, then pulses
//                data_send_finish for one clock.
//  Ports       : clk  - system clock, rising edge
//                rst  - asynchronous, active-high reset
//                bus  - uart_data_sender_if.master (run request, buffer read
//                       port, txd, busy, data_send_finish)
//  Parameters  : DATA_COUNT - bytes per run
//                ADDR_W     - buffer address width (2**ADDR_W >= DATA_COUNT)
//                BAUD_DIV   - clocks per UART bit (>= 2)
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_data_sender #(
    parameter int DATA_COUNT = 10000,
    parameter int ADDR_W     = 14,
    parameter int BAUD_DIV   = 5208
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_data_sender_if.master   bus
);

    localparam int                c_cnt_w     = $clog2(BAUD_DIV);
    localparam logic [c_cnt_w-1:0] c_baud_last = c_cnt_w'(BAUD_DIV - 1);
    localparam logic [c_cnt_w-1:0] c_baud_one  = c_cnt_w'(1);
    localparam logic [ADDR_W-1:0]  c_last_idx  = ADDR_W'(DATA_COUNT - 1);
    localparam logic [ADDR_W-1:0]  c_idx_one   = ADDR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_START = 3'd3,
        S_DATA  = 3'd4,
        S_STOP  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic                 r_run_d;
    logic [c_cnt_w-1:0]   r_baud_cnt;
    logic [c_cnt_w-1:0]   w_baud_cnt_next;
    logic [2:0]           r_bit_cnt;
    logic [2:0]           w_bit_cnt_next;
    logic [7:0]           r_shift;
    logic [7:0]           w_shift_next;
    logic [ADDR_W-1:0]    r_index;
    logic [ADDR_W-1:0]    w_index_next;
    logic                 r_txd;
    logic                 w_txd_next;

    logic                 w_start;
    logic                 w_baud_end;
    logic                 w_last_byte;

    // Rising edge of the run level; only acted on in IDLE.
    assign w_start     = bus.data_send_run & ~r_run_d;
    assign w_baud_end  = (r_baud_cnt == c_baud_last);
    assign w_last_byte = (r_index == c_last_idx);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next    = r_state;
        w_bit_cnt_next  = r_bit_cnt;
        w_shift_next    = r_shift;
        w_index_next    = r_index;
        w_baud_cnt_next = '0;
        w_txd_next      = 1'b1;

        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                w_state_next = S_LOAD;
            end
            S_LOAD: begin
                // RAM data for the FETCH address is valid in this cycle.
                w_shift_next   = bus.rd_data;
                w_bit_cnt_next = 3'd0;
                w_state_next   = S_START;
            end
            S_START: begin
                if (w_baud_end) begin
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_baud_end) begin
                    w_shift_next = {1'b0, r_shift[7:1]};
                    if (r_bit_cnt == 3'd7) begin
                        w_state_next = S_STOP;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (w_baud_end) begin
                    if (w_last_byte) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_index_next = r_index + c_idx_one;
                        w_state_next = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                w_index_next = '0;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        // Baud counter restarts on every state entry and after each bit.
        if (w_state_next == r_state &&
            (r_state == S_START || r_state == S_DATA || r_state == S_STOP)) begin
            w_baud_cnt_next = w_baud_end ? '0 : r_baud_cnt + c_baud_one;
        end

        // txd is derived from the upcoming state so the registered line
        // changes on the same edge as the state it belongs to.
        case (w_state_next)
            S_START: w_txd_next = 1'b0;
            S_DATA:  w_txd_next = w_shift_next[0];
            default: w_txd_next = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run_d    <= 1'b0;
            r_baud_cnt <= '0;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'd0;
            r_index    <= '0;
            r_txd      <= 1'b1;
        end else begin
            r_run_d    <= bus.data_send_run;
            r_baud_cnt <= w_baud_cnt_next;
            r_bit_cnt  <= w_bit_cnt_next;
            r_shift    <= w_shift_next;
            r_index    <= w_index_next;
            r_txd      <= w_txd_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Index is zero whenever the FSM is idle, so rd_addr reads 0 there.
    assign bus.rd_en            = (r_state == S_FETCH);
    assign bus.rd_addr          = r_index;
    assign bus.txd              = r_txd;
    assign bus.busy             = (r_state != S_IDLE);
    assign bus.data_send_finish = (r_state == S_DONE);

endmodule
`default_nettype wire
